arb_matrix_lru: RTL and testbench
=================================

// Module: arb_matrix_lru
// PURPOSE
//  Stateful least-recently-granted matrix arbiter with a valid/ready output handshake.
//  Keeps its own WIDTH x WIDTH priority matrix, so no caller matrix is needed.
//  Optional packet lock holds a grant until the last beat. Used in front of shared
//  buses and crossbar output ports.
// PARAMETERS
//  WIDTH    4  number of requesters (>=1)
//  LOCK_EN  0  1: grant held from first accepted beat until beat with v_last; 0: v_last ignored
//  IDX_W    $clog2(WIDTH>1?WIDTH:2)  width of grant_idx (derived, do not override)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  v_vld      in   WIDTH    per-requester request valid
//  v_last     in   WIDTH    per-requester last beat of packet (used only when LOCK_EN=1)
//  gnt_rdy    in   1        downstream accepts granted beat this cycle
//  v_grant    out  WIDTH    one-hot grant, zero when no winner
//  grant_vld  out  1        |v_grant
//  grant_idx  out  IDX_W    binary index of v_grant, 0 when grant_vld=0
//  locked     out  1        lock held (registered)
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
//  State:
//   - prio[i][j]=1 means i beats j. Store only i<j (WIDTH*(WIDTH-1)/2 flops).
//   - prio[j][i] = ~prio[i][j]. The diagonal is implicitly 0.
//  Reset values: prio[i][j]=1 for all i<j (index 0 highest), lock_q=0, lock_idx=0.
//  Grant (combinational, zero latency from v_vld and state):
//   - Unlocked: v_grant[i] = v_vld[i] & ~|(v_vld & col_i), where col_i[j] = prio[j][i].
//   - Locked: v_grant = v_vld[lock_idx] ? onehot(lock_idx) : 0. Other requesters are
//     never granted while locked.
//  fire = grant_vld & gnt_rdy. State changes only on fire; no fire means all state holds.
//  upd  = fire & (LOCK_EN ? v_last[grant_idx] : 1).
//  On upd, with g = grant_idx: prio[g][j]<=0 and prio[j][g]<=1 for all j!=g. The winner
//   becomes lowest priority; the relative order of the others is unchanged.
//  Lock (LOCK_EN=1 only):
//   - fire & ~v_last[g] & ~lock_q: lock_q<=1, lock_idx<=g.
//   - fire & v_last[g]: lock_q<=0. This includes a single-beat packet, which never locks.
//   - The locked requester dropping v_vld gives grant_vld=0 and keeps the lock (a bubble,
//     not a release).
//  LOCK_EN=0: lock_q stays 0, locked=0, every fire updates the matrix.
//  Boundaries:
//   - WIDTH=1: v_grant=v_vld, grant_idx=0, matrix has no flops.
//   - All v_vld=0: v_grant=0, grant_idx=0, no state change, even if gnt_rdy=1.
//   - gnt_rdy=0 with requests present: the grant is shown and may change next cycle if
//     v_vld changes. The grant is not sticky unless locked.
//   - v_grant is always one-hot or zero. The matrix stays a strict total order, so a
//     tie is impossible.
//   - Reset asserted mid-packet: the lock is dropped immediately (async) and the matrix
//     returns to the reset order.
// STRUCTURE
//  Package arb_pkg holds:
//   - function onehot2idx #(WIDTH) (returns IDX_W bits);
//   - function init_prio(i,j) returning i<j;
//   - typedef arb_lock_t {logic locked; logic [IDX_W-1:0] idx;}.
//  Sub-module arb_matrix_prio_reg holds the upper-triangle flops.
//   - Inputs: clk, rst_n, upd, upd_idx.
//   - Output: the full WIDTH x WIDTH matrix array, expanded with complement and a 0 diagonal.
//  Top level holds the grant logic, fire/upd, the lock register and grant_idx encode.
// TESTING
//  1. Reset, WIDTH=4, LOCK_EN=0, v_vld=4'b1111, gnt_rdy=1 for 8 cycles.
//     -> grant_idx 0,1,2,3,0,1,2,3.
//  2. v_vld=4'b1010, gnt_rdy=0 for 3 cycles, then 1.
//     -> v_grant=4'b0010 held with no matrix change; after fire, next grant 4'b1000.
//  3. From reset, grant 3 once, then v_vld=4'b1001.
//     -> grant_idx=0; index 3 last-granted loses until 0 is granted.
//  4. LOCK_EN=1, v_vld=4'b0011. Req0 sends 3 beats, v_last on the third.
//     -> v_grant=4'b0001 for all 3 fires and locked=1 for 2 cycles; then grant 4'b0010.
//  5. LOCK_EN=1, locked on idx 2, v_vld[2] drops for 2 cycles while v_vld[1]=1.
//     -> v_grant=0, locked stays 1; resumes 4'b0100.
//  6. rst_n pulsed low mid-lock (async, between edges).
//     -> locked=0 at once; after release the reset order applies (v_vld=4'b1111 grants 0).
//  Always-on assertions:
//   - $onehot0(v_grant);
//   - v_grant implies v_vld;
//   - prio encodes a strict total order: each requester beats a distinct count
//     (0..WIDTH-1) of the others.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the least-recently-granted matrix arbiter.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package arb_pkg;

    // Upper bound on requester count; helpers are sized to this and callers cast down.
    localparam int ARB_MAX_W   = 32;
    localparam int ARB_IDX_MAX = $clog2(ARB_MAX_W);

    // Lock register: the holder index is kept at full helper width so one type
    // serves every arbiter size.
    typedef struct packed {
        logic                   locked;
        logic [ARB_IDX_MAX-1:0] idx;
    } arb_lock_t;

    // One-hot to binary. OR-encoding is exact for one-hot input and gives 0 for zero input.
    function automatic logic [ARB_IDX_MAX-1:0] onehot2idx(input logic [ARB_MAX_W-1:0] vec);
        logic [ARB_IDX_MAX-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (vec[i]) begin
                idx = idx | ARB_IDX_MAX'(i);
            end
        end
        return idx;
    endfunction

    // Reset priority: lower index beats higher index.
    function automatic logic init_prio(input int i, input int j);
        return (i < j);
    endfunction

endpackage

// File: rtl/arb_matrix_prio_reg.sv
// Upper-triangle priority flops, expanded to the full WIDTH x WIDTH matrix.
// Latency: matrix reflects an update on the cycle after upd.
// Backpressure: none; updates only when upd is asserted, otherwise holds.
module arb_matrix_prio_reg
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH > 1 ? WIDTH : 2)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         upd,
    input  logic [IDX_W-1:0]             upd_idx,
    output logic [WIDTH-1:0][WIDTH-1:0]  prio
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            if (i < j) begin : g_flop
                logic q;

                // Winner drops below every other requester; pairs not involving it hold.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q <= init_prio(i, j);
                    end else if (upd && (upd_idx == IDX_W'(i))) begin
                        q <= 1'b0;
                    end else if (upd && (upd_idx == IDX_W'(j))) begin
                        q <= 1'b1;
                    end
                end

                assign prio[i][j] = q;
                assign prio[j][i] = ~q;
            end else if (i == j) begin : g_diag
                assign prio[i][j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/arb_matrix_lru.sv
// Least-recently-granted matrix arbiter with optional packet lock.
// Latency: grant is combinational from v_vld and state; state updates on the fire edge.
// Backpressure: gnt_rdy=0 holds all state; the grant follows v_vld unless a lock is held.
module arb_matrix_lru
    import arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LOCK_EN = 0,
    parameter int IDX_W   = $clog2(WIDTH > 1 ? WIDTH : 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] v_vld,
    input  logic [WIDTH-1:0] v_last,
    input  logic             gnt_rdy,
    output logic [WIDTH-1:0] v_grant,
    output logic             grant_vld,
    output logic [IDX_W-1:0] grant_idx,
    output logic             locked
);

    logic [WIDTH-1:0][WIDTH-1:0] prio;
    logic [WIDTH-1:0]            grant_free;
    logic [WIDTH-1:0]            lock_hit;
    logic [WIDTH-1:0]            order_seen;
    arb_lock_t                   lock_r;
    logic                        fire;
    logic                        last_hit;
    logic                        upd;

    arb_matrix_prio_reg #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio (
        .clk     (clk),
        .rst_n   (rst_n),
        .upd     (upd),
        .upd_idx (grant_idx),
        .prio    (prio)
    );

    // Unlocked winner: a requester wins when no other active requester beats it.
    always_comb begin
        grant_free = '0;
        for (int i = 0; i < WIDTH; i++) begin
            grant_free[i] = v_vld[i];
            for (int j = 0; j < WIDTH; j++) begin
                if (v_vld[j] && prio[j][i]) begin
                    grant_free[i] = 1'b0;
                end
            end
        end
    end

    // Decode the lock holder; only that requester may be granted while locked.
    always_comb begin
        lock_hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lock_hit[i] = (lock_r.idx == ARB_IDX_MAX'(i));
        end
    end

    assign v_grant   = lock_r.locked ? (v_vld & lock_hit) : grant_free;
    assign grant_vld = |v_grant;
    assign grant_idx = IDX_W'(onehot2idx(ARB_MAX_W'(v_grant)));
    assign locked    = lock_r.locked;

    // v_grant is one-hot, so masking v_last with it selects the winner's last flag.
    assign last_hit = |(v_last & v_grant);
    assign fire     = grant_vld & gnt_rdy;
    assign upd      = fire & ((LOCK_EN != 0) ? last_hit : 1'b1);

    // Lock opens on the first non-last accepted beat and closes on the accepted last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r <= '0;
        end else if ((LOCK_EN != 0) && fire) begin
            if (last_hit) begin
                lock_r.locked <= 1'b0;
            end else if (!lock_r.locked) begin
                lock_r.locked <= 1'b1;
                lock_r.idx    <= ARB_IDX_MAX'(grant_idx);
            end
        end
    end

    // Each requester must beat a distinct number of others for the matrix to be a total order.
    always_comb begin
        order_seen = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < WIDTH; k++) begin
                if ($countones(prio[i]) == k) begin
                    order_seen[k] = 1'b1;
                end
            end
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(v_grant));
    a_grant_has_req: assert property (@(posedge clk) disable iff (!rst_n) ((v_grant & ~v_vld) == '0));
    a_total_order:   assert property (@(posedge clk) disable iff (!rst_n) (&order_seen));

endmodule

// File: tb/tb_arb_matrix_lru.sv
// Directed bench for arb_matrix_lru: one unlocked and one lock-enabled instance.
// Latency: checks combinational grant mid-cycle, state effects after each edge.
// Backpressure: exercises gnt_rdy stalls, lock bubbles and async reset mid-packet.
module tb_arb_matrix_lru;

    logic       clk;
    logic       rst_n;

    logic [3:0] v_vld0, v_last0, v_grant0;
    logic       gnt_rdy0, grant_vld0, locked0;
    logic [1:0] grant_idx0;

    logic [3:0] v_vld1, v_last1, v_grant1;
    logic       gnt_rdy1, grant_vld1, locked1;
    logic [1:0] grant_idx1;

    int checks;
    int failures;

    arb_matrix_lru #(.WIDTH(4), .LOCK_EN(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .v_vld     (v_vld0),
        .v_last    (v_last0),
        .gnt_rdy   (gnt_rdy0),
        .v_grant   (v_grant0),
        .grant_vld (grant_vld0),
        .grant_idx (grant_idx0),
        .locked    (locked0)
    );

    arb_matrix_lru #(.WIDTH(4), .LOCK_EN(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .v_vld     (v_vld1),
        .v_last    (v_last1),
        .gnt_rdy   (gnt_rdy1),
        .v_grant   (v_grant1),
        .grant_vld (grant_vld1),
        .grant_idx (grant_idx1),
        .locked    (locked1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected round-robin order from reset under full request load.
    logic [1:0] rr_exp [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        v_vld0   = '0; v_last0 = '0; gnt_rdy0 = 1'b0;
        v_vld1   = '0; v_last1 = '0; gnt_rdy1 = 1'b0;

        #1;
        chk("rst_grant_vld0", {31'd0, grant_vld0}, 32'd0);
        chk("rst_grant_idx0", {30'd0, grant_idx0}, 32'd0);
        chk("rst_locked1",    {31'd0, locked1},    32'd0);
        #20 rst_n = 1'b1;
        step();

        // Idle with ready high: no request, no grant, no state change.
        gnt_rdy0 = 1'b1;
        #1;
        chk("idle_grant0", {28'd0, v_grant0}, 32'd0);
        step();

        // Full load rotates 0,1,2,3,0,1,2,3.
        v_vld0 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_idx%0d", k), {30'd0, grant_idx0}, {30'd0, rr_exp[k]});
            chk($sformatf("rr_gnt%0d", k), {28'd0, v_grant0}, 32'd1 << rr_exp[k]);
            step();
        end

        // Stall: grant shown but held; after the fire, index 3 overtakes index 1.
        v_vld0   = 4'b1010;
        gnt_rdy0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall_gnt%0d", k), {28'd0, v_grant0}, 32'h2);
            step();
        end
        gnt_rdy0 = 1'b1;
        #1;
        chk("stall_fire_gnt", {28'd0, v_grant0}, 32'h2);
        step();
        chk("after_stall_gnt", {28'd0, v_grant0}, 32'h8);
        step();
        gnt_rdy0 = 1'b0;
        // Order is now 0,2,1,3; 2 beats 1.
        v_vld0 = 4'b0110;
        #1;
        chk("pre_rst_gnt", {28'd0, v_grant0}, 32'h4);

        // Reset restores the default order: 1 beats 2 again.
        @(posedge clk); #3 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", {28'd0, v_grant0}, 32'h2);
        step();

        // Granting 3 alone leaves 0 ahead; after 0 is granted, 3 wins.
        v_vld0   = 4'b1000;
        gnt_rdy0 = 1'b1;
        #1;
        chk("solo3_gnt", {28'd0, v_grant0}, 32'h8);
        step();
        v_vld0 = 4'b1001;
        #1;
        chk("lru_first_idx", {30'd0, grant_idx0}, 32'd0);
        step();
        chk("lru_second_idx", {30'd0, grant_idx0}, 32'd3);
        gnt_rdy0 = 1'b0;
        v_vld0   = '0;

        // Lock: 3-beat packet on requester 0 while 1 also requests.
        v_vld1   = 4'b0011;
        gnt_rdy1 = 1'b1;
        #1;
        chk("pkt_b0_gnt", {28'd0, v_grant1}, 32'h1);
        chk("pkt_b0_lock", {31'd0, locked1}, 32'd0);
        step();
        chk("pkt_b1_gnt", {28'd0, v_grant1}, 32'h1);
        chk("pkt_b1_lock", {31'd0, locked1}, 32'd1);
        step();
        v_last1 = 4'b0001;
        #1;
        chk("pkt_b2_gnt", {28'd0, v_grant1}, 32'h1);
        chk("pkt_b2_lock", {31'd0, locked1}, 32'd1);
        step();
        // Single-beat packet on 1 must not lock. Order afterwards: 2,3,0,1.
        v_vld1  = 4'b0010;
        v_last1 = 4'b0010;
        #1;
        chk("pkt_next_gnt", {28'd0, v_grant1}, 32'h2);
        chk("pkt_next_lock", {31'd0, locked1}, 32'd0);
        step();
        chk("single_beat_lock", {31'd0, locked1}, 32'd0);

        // Lock on 2, then 2 drops: bubble, lock kept even though 1 requests.
        v_vld1  = 4'b0100;
        v_last1 = 4'b0000;
        #1;
        chk("lk2_gnt", {28'd0, v_grant1}, 32'h4);
        step();
        v_vld1 = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("bubble_gnt%0d", k), {28'd0, v_grant1}, 32'd0);
            chk($sformatf("bubble_lock%0d", k), {31'd0, locked1}, 32'd1);
            step();
        end
        v_vld1 = 4'b0110;
        #1;
        chk("resume_gnt", {28'd0, v_grant1}, 32'h4);
        chk("resume_idx", {30'd0, grant_idx1}, 32'd2);
        gnt_rdy1 = 1'b0;

        // Async reset between edges drops the lock immediately.
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_rst_lock", {31'd0, locked1}, 32'd0);
        #2 rst_n = 1'b1;
        #1;
        v_vld1 = 4'b1111;
        v_vld0 = 4'b1111;
        #1;
        chk("rst_order_gnt1", {28'd0, v_grant1}, 32'h1);
        chk("rst_order_gnt0", {28'd0, v_grant0}, 32'h1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
